fp_mul_norm_round: RTL
======================

# fp_mul_norm_round

Normalize-and-round stage of the FP32 multiplier datapath. It accepts the raw 48-bit significand product, the raw exponent sum and the sign from the multiply array, then produces the packed sign, exponent and 24-bit significand that the result register captures. It is a 2-stage valid/ready pipeline (normalize, round) with full throughput and backpressure.

## Interface
- No parameters. Widths are fixed by package constants.
- clock  in  1  rising-edge clock
- resetn  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat present
- in_ready  out  1  stage can accept input this cycle (combinational)
- in_sign  in  1  product sign (sa ^ sb)
- in_exp_sum  in  10  ea + eb, both biased, unsigned
- in_product  in  48  24x24 significand product, hidden bits included
- in_zero / in_inf / in_nan  in  1 each  operand class flags from upstream
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_sign  out  1  result sign
- out_exponent  out  8  biased result exponent
- out_significand  out  24  result significand; bit 23 is the hidden bit
- out_flags  out  3  {overflow, underflow, inexact}

## Operation
- Stage 1 (normalize):
  - n = in_product[47].
  - If n = 1: mant = p[47:24], guard = p[23], sticky = |p[22:0].
  - If n = 0: mant = p[46:23], guard = p[22], sticky = |p[21:0].
  - e = in_exp_sum − 127 + n, held as signed 11-bit.
- Stage 2 (round):
  - Apply round-up per Configuration.
  - If mant + 1 carries out of 24 bits: mant = 0x800000 and e = e + 1.
  - inexact = guard | sticky.
- Exceptions, applied in stage 2 after rounding, in priority order:
  - in_nan, or in_inf & in_zero: exp 255, sig 0xC00000, sign 0, flags 0.
  - in_inf: exp 255, sig 0x800000, sign kept.
  - in_zero: exp 0, sig 0, sign kept, flags 0.
  - e ≥ 255: exp 255, sig 0x800000 (infinity), overflow = 1, inexact = 1.
  - e ≤ 0: exp 0, sig 0, sign kept (flush to zero, no subnormals), underflow = 1, inexact = 1.
- Handshake:
  - A beat transfers when valid & ready are both high.
  - Once out_valid is high, out_* holds stable until out_ready is asserted.
  - s2 loads when s2 is empty or out_ready = 1.
  - s1 loads when s1 is empty or s1 advances into s2.
  - in_ready = !s1_valid | s1_advance.

## Timing
- Latency: 2 cycles from accept edge to out_valid. Throughput: 1 result per cycle.
- Reset: s1_valid, s2_valid and out_valid = 0; out_sign, out_exponent, out_significand, out_flags = 0; in_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0. No beat is dropped or duplicated.
- Simultaneous out_ready and in_valid while full: both transfers occur in the same cycle.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.

## Configuration
- FP_NMR_ROUND_RNE_EN defined: round to nearest even. round_up = guard & (sticky | mant[0]).
- Not defined: truncation (round toward zero), round_up = 0. inexact is still reported.

## Structure
- Shared package fp_mac_pkg holds:
  - EXP_BIAS = 127, EXP_W = 8, SIG_W = 24, PROD_W = 48
  - QNAN_SIG = 24'hC00000
  - flag indices FLAG_OVF = 2, FLAG_UNF = 1, FLAG_INX = 0
- One sub-module: fp_nmr_rounder. It is combinational: mant/guard/sticky/e in, rounded mant/e/inexact out. It is instantiated in stage 2.

## Test plan
- 1.5×1.5: product 0x900000000000, exp_sum 254 -> sign 0, exp 128, sig 0x900000 (0x40100000), flags 0, 2 cycles after accept.
- Round carry: product 0xFFFFFFC00000, exp_sum 254, RNE -> exp 129, sig 0x800000 (0x40800000), inexact 1. Truncate build -> exp 128, sig 0xFFFFFF.
- Tie-to-even: product 0x400000400000, exp_sum 254 -> sig 0x800000, exp 127, inexact 1. Product 0x400000C00000 -> sig 0x800002 under RNE.
- Overflow/underflow: exp_sum 400, product 0x400000000000 -> exp 255, sig 0x800000, flags 3'b101. exp_sum 100 -> exp 0, sig 0, flags 3'b011.
- Specials: in_inf & in_zero -> exp 255, sig 0xC00000. in_zero alone with sign 1 -> 0x80000000 packed, flags 0.
- Backpressure/reset:
  - Offer 4 back-to-back beats with out_ready = 0 -> exactly 2 accepted, in_ready low, outputs stable.
  - Release out_ready -> all 4 results emerge in order.
  - Assert resetn low with 2 beats in flight -> out_valid = 0 on the next edge and no stale result afterwards.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Shared constants and types for the FP32 multiply datapath.
// Rounding mode is selected by FP_NMR_ROUND_RNE_EN (defined: RNE, undefined: truncate).
package fp_mac_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int SIG_W    = 24;
    localparam int PROD_W   = 48;
    localparam int EXPS_W   = 11;

    localparam logic [SIG_W-1:0] QNAN_SIG   = 24'hC00000;
    localparam logic [SIG_W-1:0] HIDDEN_ONE = 24'h800000;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [SIG_W-1:0] significand;
        logic [2:0]       flags;
    } fp_result_t;

endpackage

// File: rtl/fp_nmr_rounder.sv
// Combinational rounder: applies round-up to the normalized significand and
// propagates a carry-out into the exponent. Mode chosen by FP_NMR_ROUND_RNE_EN.
module fp_nmr_rounder
    import fp_mac_pkg::*;
(
    input  logic                     [SIG_W-1:0]  mant,
    input  logic                                  guard,
    input  logic                                  sticky,
    input  logic signed              [EXPS_W-1:0] exp_in,
    output logic                     [SIG_W-1:0]  mant_out,
    output logic signed              [EXPS_W-1:0] exp_out,
    output logic                                  inexact
);

`ifdef FP_NMR_ROUND_RNE_EN
    function automatic logic round_rne(input logic lsb, input logic g, input logic s);
        return g & (s | lsb);
    endfunction
`endif

    logic             round_up;
    logic [SIG_W:0]   sum;
    logic             carry;

`ifdef FP_NMR_ROUND_RNE_EN
    assign round_up = round_rne(mant[0], guard, sticky);
`else
    assign round_up = 1'b0;
`endif

    assign sum      = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
    assign carry    = sum[SIG_W];
    // A carry out of 24 bits means the significand became 2.0: renormalize.
    assign mant_out = carry ? HIDDEN_ONE : sum[SIG_W-1:0];
    assign exp_out  = exp_in + $signed({{(EXPS_W-1){1'b0}}, carry});
    assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_mul_norm_round.sv
// FP32 multiplier normalize/round stage: 2-stage valid/ready pipeline.
// Optional macro FP_NMR_ROUND_RNE_EN selects round-to-nearest-even (default: truncate).
module fp_mul_norm_round
    import fp_mac_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [9:0]          in_exp_sum,
    input  logic [PROD_W-1:0]   in_product,
    input  logic                in_zero,
    input  logic                in_inf,
    input  logic                in_nan,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [EXP_W-1:0]    out_exponent,
    output logic [SIG_W-1:0]    out_significand,
    output logic [2:0]          out_flags
);

    localparam logic signed [EXPS_W-1:0] EXP_MAX = 11'sd255;
    localparam logic signed [EXPS_W-1:0] EXP_MIN = 11'sd0;

    function automatic fp_result_t finish_result(
        input logic                     sign,
        input logic                     zero,
        input logic                     inf,
        input logic                     nan,
        input logic        [SIG_W-1:0]  mant,
        input logic signed [EXPS_W-1:0] e,
        input logic                     inexact
    );
        fp_result_t r;
        r.sign             = sign;
        r.exponent         = e[EXP_W-1:0];
        r.significand      = mant;
        r.flags            = '0;
        r.flags[FLAG_INX]  = inexact;
        if (nan || (inf && zero)) begin
            r.sign        = 1'b0;
            r.exponent    = '1;
            r.significand = QNAN_SIG;
            r.flags       = '0;
        end else if (inf) begin
            r.exponent    = '1;
            r.significand = HIDDEN_ONE;
            r.flags       = '0;
        end else if (zero) begin
            r.exponent    = '0;
            r.significand = '0;
            r.flags       = '0;
        end else if (e >= EXP_MAX) begin
            r.exponent        = '1;
            r.significand     = HIDDEN_ONE;
            r.flags           = '0;
            r.flags[FLAG_OVF] = 1'b1;
            r.flags[FLAG_INX] = 1'b1;
        end else if (e <= EXP_MIN) begin
            r.exponent        = '0;
            r.significand     = '0;
            r.flags           = '0;
            r.flags[FLAG_UNF] = 1'b1;
            r.flags[FLAG_INX] = 1'b1;
        end
        return r;
    endfunction

    logic                     vld_p1, vld_p2;
    logic                     load_p2, adv_p1;
    logic                     n_p0;
    logic        [SIG_W-1:0]  mant_p0, mant_p1;
    logic                     guard_p0, guard_p1;
    logic                     sticky_p0, sticky_p1;
    logic signed [EXPS_W-1:0] exp_p0, exp_p1;
    logic                     sign_p1, zero_p1, inf_p1, nan_p1;
    logic        [SIG_W-1:0]  mant_rnd;
    logic signed [EXPS_W-1:0] exp_rnd;
    logic                     inexact_rnd;
    fp_result_t               res_nxt, res_p2;

    assign load_p2  = !vld_p2 || out_ready;
    assign adv_p1   = vld_p1 && load_p2;
    assign in_ready = !vld_p1 || adv_p1;

    // Stage 1: normalize the raw product
    always_comb begin
        n_p0 = in_product[PROD_W-1];
        if (n_p0) begin
            mant_p0   = in_product[47:24];
            guard_p0  = in_product[23];
            sticky_p0 = |in_product[22:0];
        end else begin
            mant_p0   = in_product[46:23];
            guard_p0  = in_product[22];
            sticky_p0 = |in_product[21:0];
        end
        exp_p0 = $signed({1'b0, in_exp_sum}) - $signed(EXPS_W'(EXP_BIAS))
               + $signed({{(EXPS_W-1){1'b0}}, n_p0});
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (in_ready && in_valid) begin
            mant_p1   <= mant_p0;
            guard_p1  <= guard_p0;
            sticky_p1 <= sticky_p0;
            exp_p1    <= exp_p0;
            sign_p1   <= in_sign;
            zero_p1   <= in_zero;
            inf_p1    <= in_inf;
            nan_p1    <= in_nan;
        end
    end

    // Stage 2: round, then resolve specials and range
    fp_nmr_rounder u_rounder (
        .mant     (mant_p1),
        .guard    (guard_p1),
        .sticky   (sticky_p1),
        .exp_in   (exp_p1),
        .mant_out (mant_rnd),
        .exp_out  (exp_rnd),
        .inexact  (inexact_rnd)
    );

    assign res_nxt = finish_result(sign_p1, zero_p1, inf_p1, nan_p1,
                                   mant_rnd, exp_rnd, inexact_rnd);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2 <= res_nxt;
            end
        end
    end

    assign out_valid       = vld_p2;
    assign out_sign        = res_p2.sign;
    assign out_exponent    = res_p2.exponent;
    assign out_significand = res_p2.significand;
    assign out_flags       = res_p2.flags;

endmodule
